mpu_controller: RTL

Front-end instruction sequencer for the MPU. It accepts one MPU instruction at a time (NOP/LOAD/STORE/MULT) from the bus interface and checks it against a per-register scoreboard covering pending writes, pending reads, stored dimensions and a valid flag. It then issues start pulses to the load unit, the store unit and the multiply dispatcher. The three units may run concurrently; the controller enforces register hazards and dimension legality between them.

---
 rtl/mpu_data_types.sv | 32 +++
 rtl/mpu_scoreboard.sv | 120 ++++++++++++
 rtl/mpu_controller.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mpu_data_types.sv
// Shared types and sizing for the MPU front end.
// Holds instruction/state/error enums, the per-register dimension record and
// the latched instruction record passed from the sequencer to the scoreboard.
package mpu_data_types;
  localparam int MATRIX_REGISTERS = 8;
  localparam int M = 3;
  localparam int N = 3;
  // *_BITS are msb indices, so fields are declared [X_BITS:0].
  localparam int MATRIX_REG_BITS = $clog2(MATRIX_REGISTERS) - 1;
  localparam int MBITS = $clog2(M + 1) - 1;
  localparam int NBITS = $clog2(N + 1) - 1;

  typedef logic [MATRIX_REG_BITS:0] reg_addr_t;

  typedef enum logic [1:0] {MPU_NOP, MPU_LOAD, MPU_STORE, MPU_MULT} mpu_instruction_e;
  typedef enum logic [1:0] {CTRL_IDLE, CTRL_HOLD} ctrl_state_e;
  typedef enum logic [1:0] {ERR_NONE, ERR_DIMS, ERR_ALIAS, ERR_UNLOADED} ctrl_err_e;

  typedef struct packed {
    logic [MBITS:0] m;
    logic [NBITS:0] n;
  } reg_dims_t;

  typedef struct packed {
    mpu_instruction_e op;
    logic [MBITS:0]   m;
    logic [NBITS:0]   n;
    reg_addr_t        src0;
    reg_addr_t        src1;
    reg_addr_t        dest;
  } mpu_instr_t;
endpackage

// File: rtl/mpu_scoreboard.sv
// Register scoreboard for the MPU sequencer.
// Tracks unit busy flags with their latched addresses, register valid bits and
// stored dimensions, and classifies the held instruction as error / stall.
//   clk, rst            clock, async active-low reset
//   instr, issue        held instruction; issue commits it to the scoreboard
//   *_done              completion pulses from load/store/mult units
//   stall, err_code     combinational verdict on instr (err_code wins)
//   units_free          no unit busy (hence nothing pending)
module mpu_scoreboard
  import mpu_data_types::*;
(
  input  logic       clk,
  input  logic       rst,
  input  mpu_instr_t instr,
  input  logic       issue,
  input  logic       load_done,
  input  logic       store_done,
  input  logic       mult_done,
  output logic       stall,
  output ctrl_err_e  err_code,
  output logic       units_free
);
  logic load_busy, store_busy, mult_busy;
  reg_addr_t ld_dest, st_src, mu_src0, mu_src1, mu_dest;
  logic [MATRIX_REGISTERS-1:0] valid, pend_w, pend_r;
  reg_dims_t [MATRIX_REGISTERS-1:0] dims;
  logic a_bad, b_bad;

  // Pending masks are rebuilt from the busy units' latched addresses, so a
  // register read by two units at once stays pending until both finish.
  always_comb begin
    pend_w = '0;
    pend_r = '0;
    if (load_busy) pend_w[ld_dest] = 1'b1;
    if (store_busy) pend_r[st_src] = 1'b1;
    if (mult_busy) begin
      pend_w[mu_dest] = 1'b1;
      pend_r[mu_src0] = 1'b1;
      pend_r[mu_src1] = 1'b1;
    end
  end

  assign units_free = !(load_busy || store_busy || mult_busy);

  always_comb begin
    a_bad    = !valid[instr.src0] && !pend_w[instr.src0];
    b_bad    = !valid[instr.src1] && !pend_w[instr.src1];
    err_code = ERR_NONE;
    stall    = 1'b0;
    case (instr.op)
      MPU_LOAD: begin
        if (instr.m == '0 || instr.n == '0) err_code = ERR_DIMS;
        stall = load_busy || pend_w[instr.dest] || pend_r[instr.dest];
      end
      MPU_STORE: begin
        if (a_bad) err_code = ERR_UNLOADED;
        stall = store_busy || pend_w[instr.src0];
      end
      MPU_MULT: begin
        if (a_bad || b_bad)
          err_code = ERR_UNLOADED;
        else if (instr.dest == instr.src0 || instr.dest == instr.src1)
          err_code = ERR_ALIAS;
        else if (32'(dims[instr.src0].n) != 32'(dims[instr.src1].m))
          err_code = ERR_DIMS;
        stall = mult_busy || pend_w[instr.src0] || pend_w[instr.src1] ||
                pend_w[instr.dest] || pend_r[instr.dest];
      end
      default: ;
    endcase
  end

  // Dones are gated by busy so stray pulses are ignored. An issue never
  // targets a unit completing in the same cycle (busy stalls it).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_busy  <= 1'b0;
      store_busy <= 1'b0;
      mult_busy  <= 1'b0;
      ld_dest    <= '0;
      st_src     <= '0;
      mu_src0    <= '0;
      mu_src1    <= '0;
      mu_dest    <= '0;
      valid      <= '0;
      dims       <= '0;
    end else begin
      if (load_done && load_busy) begin
        load_busy      <= 1'b0;
        valid[ld_dest] <= 1'b1;
      end
      if (store_done && store_busy) store_busy <= 1'b0;
      if (mult_done && mult_busy) begin
        mult_busy      <= 1'b0;
        valid[mu_dest] <= 1'b1;
      end
      if (issue) begin
        case (instr.op)
          MPU_LOAD: begin
            load_busy        <= 1'b1;
            ld_dest          <= instr.dest;
            dims[instr.dest] <= '{m: instr.m, n: instr.n};
          end
          MPU_STORE: begin
            store_busy <= 1'b1;
            st_src     <= instr.src0;
          end
          MPU_MULT: begin
            mult_busy        <= 1'b1;
            mu_src0          <= instr.src0;
            mu_src1          <= instr.src1;
            mu_dest          <= instr.dest;
            dims[instr.dest] <= '{m: dims[instr.src0].m, n: dims[instr.src1].n};
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: rtl/mpu_controller.sv
// MPU front-end instruction sequencer.
// Accepts one instruction (req && ready), holds it until the scoreboard
// reports it legal and hazard-free, then pulses the matching unit start or
// reports a rejection on err/err_code.
//   req/ready/op/m_in/n_in/src_addr_*/dest_addr   instruction handshake
//   load_*/store_*/mult_*                         unit start pulses + operands, dones
//   err/err_code                                  one-cycle rejection report
//   idle                                          nothing held, nothing in flight
module mpu_controller
  import mpu_data_types::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  output logic                   ready,
  input  logic [1:0]             op,
  input  logic [MBITS:0]         m_in,
  input  logic [NBITS:0]         n_in,
  input  logic [MATRIX_REG_BITS:0] src_addr_0,
  input  logic [MATRIX_REG_BITS:0] src_addr_1,
  input  logic [MATRIX_REG_BITS:0] dest_addr,
  output logic                   load_start,
  output logic [MATRIX_REG_BITS:0] load_dest,
  output logic [MBITS:0]         load_m,
  output logic [NBITS:0]         load_n,
  input  logic                   load_done,
  output logic                   store_start,
  output logic [MATRIX_REG_BITS:0] store_src,
  input  logic                   store_done,
  output logic                   mult_start,
  output logic [MATRIX_REG_BITS:0] mult_src0,
  output logic [MATRIX_REG_BITS:0] mult_src1,
  output logic [MATRIX_REG_BITS:0] mult_dest,
  input  logic                   mult_done,
  output logic                   err,
  output logic [1:0]             err_code,
  output logic                   idle
);
  ctrl_state_e state, state_nxt;
  mpu_instr_t  instr;
  ctrl_err_e   sb_err;
  logic        sb_stall, sb_free, issue, reject;

  mpu_scoreboard u_sb (
    .clk       (clk),
    .rst       (rst),
    .instr     (instr),
    .issue     (issue),
    .load_done (load_done),
    .store_done(store_done),
    .mult_done (mult_done),
    .stall     (sb_stall),
    .err_code  (sb_err),
    .units_free(sb_free)
  );

  // Errors outrank stalls: a bad instruction is rejected even if its unit is busy.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    reject    = 1'b0;
    case (state)
      CTRL_IDLE: if (req) state_nxt = CTRL_HOLD;
      CTRL_HOLD: begin
        if (instr.op == MPU_NOP) begin
          state_nxt = CTRL_IDLE;
        end else if (sb_err != ERR_NONE) begin
          reject    = 1'b1;
          state_nxt = CTRL_IDLE;
        end else if (!sb_stall) begin
          issue     = 1'b1;
          state_nxt = CTRL_IDLE;
        end
      end
      default: state_nxt = CTRL_IDLE;
    endcase
  end

  assign ready = (state == CTRL_IDLE);
  assign idle  = ready && sb_free;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= CTRL_IDLE;
      instr       <= '0;
      load_start  <= 1'b0;
      store_start <= 1'b0;
      mult_start  <= 1'b0;
      load_dest   <= '0;
      load_m      <= '0;
      load_n      <= '0;
      store_src   <= '0;
      mult_src0   <= '0;
      mult_src1   <= '0;
      mult_dest   <= '0;
      err         <= 1'b0;
      err_code    <= '0;
    end else begin
      state       <= state_nxt;
      load_start  <= issue && instr.op == MPU_LOAD;
      store_start <= issue && instr.op == MPU_STORE;
      mult_start  <= issue && instr.op == MPU_MULT;
      err         <= reject;
      err_code    <= reject ? sb_err : ERR_NONE;
      if (state == CTRL_IDLE && req)
        instr <= '{op: mpu_instruction_e'(op), m: m_in, n: n_in,
                   src0: src_addr_0, src1: src_addr_1, dest: dest_addr};
      if (issue) begin
        case (instr.op)
          MPU_LOAD: begin
            load_dest <= instr.dest;
            load_m    <= instr.m;
            load_n    <= instr.n;
          end
          MPU_STORE: store_src <= instr.src0;
          MPU_MULT: begin
            mult_src0 <= instr.src0;
            mult_src1 <= instr.src1;
            mult_dest <= instr.dest;
          end
          default: ;
        endcase
      end
    end
  end
endmodule
